// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// MDOp encodings, default latencies, FSM state type and decoder mapping.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_t;

    typedef enum logic [3:0] {
        IT_OTHER,
        IT_MULT,
        IT_MULTU,
        IT_DIV,
        IT_DIVU,
        IT_MTHI,
        IT_MTLO,
        IT_MFHI,
        IT_MFLO
    } instr_type_t;

    // Decoder-side mapping from instruction type to MDOp.
    function automatic logic [2:0] md_op_of(instr_type_t t);
        logic [2:0] op;
        op = 3'd7;
        case (t)
            IT_MULT:  op = MD_MULT;
            IT_MULTU: op = MD_MULTU;
            IT_DIV:   op = MD_DIV;
            IT_DIVU:  op = MD_DIVU;
            IT_MTHI:  op = MD_MTHI;
            IT_MTLO:  op = MD_MTLO;
            default:  op = 3'd7;
        endcase
        return op;
    endfunction

    function automatic logic md_is_start(instr_type_t t);
        return (t == IT_MULT) || (t == IT_MULTU) ||
               (t == IT_DIV)  || (t == IT_DIVU);
    endfunction

    function automatic logic md_is_write(instr_type_t t);
        return (t == IT_MTHI) || (t == IT_MTLO);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational mult/multu/div/divu datapath.
// Ports: md_op, a, b in; hi, lo (64-bit result) and div0 flag out.
module md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               sgn;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        dvsr;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [31:0]        quo_o;
    logic [31:0]        rem_o;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes so that 0x80000000 / -1
    // wraps to 0x80000000 instead of overflowing the divider.
    assign sgn   = (md_op == MD_DIV);
    assign mag_a = (sgn && a[31]) ? -a : a;
    assign mag_b = (sgn && b[31]) ? -b : b;
    assign dvsr  = (b == 32'd0) ? 32'd1 : mag_b;
    assign quo   = mag_a / dvsr;
    assign rem   = mag_a % dvsr;
    assign quo_o = (sgn && (a[31] ^ b[31])) ? -quo : quo;
    assign rem_o = (sgn && a[31]) ? -rem : rem;

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        div0 = 1'b0;
        case (md_op)
            MD_MULT:  {hi, lo} = prod_s;
            MD_MULTU: {hi, lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                hi   = rem_o;
                lo   = quo_o;
                div0 = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Ports: clk, reset, Start, MDOp, MDWrite, A, B in; Busy, HI, LO out.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        MDWrite,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    md_state_t   state;
    md_state_t   state_nx;
    logic [CW-1:0] cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_div0;
    logic [31:0] c_hi;
    logic [31:0] c_lo;
    logic        c_div0;
    logic        idle;
    logic        start_ok;
    logic        wr_hi;
    logic        wr_lo;
    logic        done;

    md_compute u_compute (
        .md_op (MDOp),
        .a     (A),
        .b     (B),
        .hi    (c_hi),
        .lo    (c_lo),
        .div0  (c_div0)
    );

    assign idle     = (state == ST_IDLE);
    assign start_ok = idle && Start && (MDOp <= MD_DIVU);
    // Start wins over a simultaneous MDWrite.
    assign wr_hi    = idle && !Start && MDWrite && (MDOp == MD_MTHI);
    assign wr_lo    = idle && !Start && MDWrite && (MDOp == MD_MTLO);
    assign done     = (state == ST_RUN) && (cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_ok) state_nx = ST_RUN;
            ST_RUN:  if (done)     state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
            HI        <= 32'd0;
            LO        <= 32'd0;
        end else begin
            if (start_ok) begin
                pend_hi   <= c_hi;
                pend_lo   <= c_lo;
                pend_div0 <= c_div0;
                cnt <= (MDOp < MD_DIV) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (state == ST_RUN) begin
                cnt <= cnt - CW'(1);
            end
            // A divide by zero keeps the old HI/LO.
            if (done && !pend_div0) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table
// plus hand sequences for reset, illegal-while-busy and back-to-back.
module tb_mult_div_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic        MDWrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int pass_cnt = 0;
    int total_cnt = 0;
    int illegal_cnt = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs [10];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .MDWrite (MDWrite),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge where Busy is low.
    task automatic write_md(input logic [2:0] op, input logic [31:0] v);
        MDWrite = 1'b1;
        MDOp = op;
        A = v;
        @(negedge clk);
        MDWrite = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n,
                          output logic hold_ok);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = HI;
        l0 = LO;
        Start = 1'b1;
        MDOp = op;
        A = a;
        B = b;
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        hold_ok = 1'b1;
        while (Busy && n < 64) begin
            n++;
            if (HI !== h0 || LO !== l0) hold_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic hold;
        logic quiet;

        vecs[0] = '{OP_MULT,  32'h00010000, 32'h00010000, 32'h0000AAAA,
                    32'h0000BBBB, 32'h00000001, 32'h00000000, 5};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11111111,
                    32'h22222222, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,
                    32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h0,
                    32'h0, 32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,
                    32'h6, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,
                    32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6] = '{OP_DIV,   32'h00000063, 32'h00000000, 32'h00001234,
                    32'h00005678, 32'h00001234, 32'h00005678, 10};
        vecs[7] = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000001,
                    32'h00000002, 32'h00000001, 32'h00000002, 10};
        vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0,
                    32'h0, 32'h40000000, 32'h00000000, 5};
        vecs[9] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h0,
                    32'h0, 32'h00000001, 32'h00000000, 5};

        reset = 1'b1;
        Start = 1'b0;
        MDOp = 3'd0;
        MDWrite = 1'b0;
        A = 32'd0;
        B = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        @(negedge clk);

        // Signed multiply straight out of reset.
        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, n, hold);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hold0", {31'd0, hold}, 32'd1);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);

        for (int i = 0; i < 10; i++) begin
            write_md(OP_MTHI, vecs[i].pre_hi);
            write_md(OP_MTLO, vecs[i].pre_lo);
            chk($sformatf("v%0d_prehi", i), HI, vecs[i].pre_hi);
            chk($sformatf("v%0d_prelo", i), LO, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n, hold);
            chk($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
            chk($sformatf("v%0d_hold", i), {31'd0, hold}, 32'd1);
            chk($sformatf("v%0d_hi", i), HI, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), LO, vecs[i].exp_lo);
        end

        // Reserved / mismatched op codes do nothing.
        write_md(OP_MTHI, 32'hCAFE0001);
        write_md(OP_MTLO, 32'hCAFE0002);
        Start = 1'b1;
        MDOp = 3'd6;
        @(negedge clk);
        Start = 1'b0;
        chk("start_op6_busy", {31'd0, Busy}, 32'd0);
        write_md(OP_MULT, 32'h0BAD0BAD);
        chk("mdwrite_op0_hi", HI, 32'hCAFE0001);
        chk("mdwrite_op0_lo", LO, 32'hCAFE0002);
        Start = 1'b1;
        MDWrite = 1'b1;
        MDOp = OP_MTHI;
        A = 32'h0BAD0BAD;
        @(negedge clk);
        Start = 1'b0;
        MDWrite = 1'b0;
        chk("start_wr_busy", {31'd0, Busy}, 32'd0);
        chk("start_wr_hi", HI, 32'hCAFE0001);

        // Reset during busy cycle 4 of a divide.
        Start = 1'b1;
        MDOp = OP_DIVU;
        A = 32'd100;
        B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_pre", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) quiet = 1'b0;
        end
        chk("midrst_no_late_write", {31'd0, quiet}, 32'd1);

        // Illegal Start and MDWrite while a multiply runs.
        Start = 1'b1;
        MDOp = OP_MULT;
        A = 32'd3;
        B = 32'd4;
        @(negedge clk);
        Start = 1'b0;
        if (Busy) illegal_cnt++;
        Start = 1'b1;
        MDOp = OP_DIVU;
        A = 32'd100;
        B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        if (Busy) illegal_cnt++;
        MDWrite = 1'b1;
        MDOp = OP_MTHI;
        A = 32'hDEADBEEF;
        @(negedge clk);
        MDWrite = 1'b0;
        n = 2;
        while (Busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("illegal_cycles", 32'(n), 32'd5);
        chk("illegal_count", 32'(illegal_cnt), 32'd2);
        chk("illegal_hi", HI, 32'd0);
        chk("illegal_lo", LO, 32'd12);

        // Start in the first cycle after Busy falls.
        run_op(OP_DIVU, 32'd100, 32'd7, n, hold);
        chk("b2b_cycles", 32'(n), 32'd10);
        chk("b2b_hold", {31'd0, hold}, 32'd1);
        chk("b2b_hi", HI, 32'd2);
        chk("b2b_lo", LO, 32'd14);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
